// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse burst generator.
package pulse_gen_pkg;

    localparam int unsigned DEF_CNT_W = 16;

    // Cycle count at the default counter width.
    typedef logic [DEF_CNT_W-1:0] cyc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } pb_state_e;

    function automatic logic is_busy(pb_state_e s);
        return s != IDLE;
    endfunction

    // True when v is representable in w bits.
    function automatic logic fits_width(int unsigned v, int unsigned w);
        return (w >= 32) || ((v >> w) == 0);
    endfunction

endpackage

// File: rtl/pulse_burst_gen_if.sv
// Control/status bundle of the pulse burst generator.
interface pulse_burst_gen_if;
    logic start;
    logic stop;
    logic out;
    logic busy;
    logic done;

    modport master (output start, output stop, input out, input busy, input done);
    modport slave  (input start, input stop, output out, output busy, output done);
endinterface

// File: rtl/cyc_downcnt.sv
// Loadable down counter with zero flag, used to time each burst phase.
module cyc_downcnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over enable; the count parks at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Burst generator: after a start, waits TD_CYC+1 clocks, then emits pulses
// of TW_CYC high within a TP_CYC period, N_PULSE times (or until stop).
module pulse_burst_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned TD_CYC  = 1,
    parameter int unsigned TW_CYC  = 4,
    parameter int unsigned TP_CYC  = 8,
    parameter int unsigned N_PULSE = 0,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    pulse_burst_gen_if.slave bus
);

    if (TW_CYC == 0 || TW_CYC >= TP_CYC) begin : g_bad_width
        $error("pulse_burst_gen: need 1 <= TW_CYC < TP_CYC (TW_CYC=%0d TP_CYC=%0d)",
               TW_CYC, TP_CYC);
    end
    if (!fits_width(TD_CYC, CNT_W) || !fits_width(TW_CYC, CNT_W) ||
        !fits_width(TP_CYC, CNT_W) || !fits_width(N_PULSE, CNT_W)) begin : g_bad_range
        $error("pulse_burst_gen: timing/count parameter does not fit in CNT_W=%0d bits",
               CNT_W);
    end

    typedef logic [CNT_W-1:0] cnt_t;

    // Phase counter runs down to zero, so each load is the phase length minus one
    // (DELAY is TD_CYC+1 clocks long, hence loaded with TD_CYC itself).
    localparam cnt_t TD_LD = cnt_t'(TD_CYC);
    localparam cnt_t HI_LD = cnt_t'(TW_CYC - 1);
    localparam cnt_t LO_LD = cnt_t'(TP_CYC - TW_CYC - 1);
    localparam cnt_t N_TGT = cnt_t'(N_PULSE);

    pb_state_e state, nxt;
    cnt_t      pulse_cnt, pulse_inc;
    cnt_t      ph_val;
    logic      ph_load, ph_en, ph_zero;
    logic      pc_clr, pc_inc, done_nxt;

    cyc_downcnt #(.W(CNT_W)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .en       (ph_en),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    assign pulse_inc = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + cnt_t'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state and phase-counter control.
    always_comb begin
        nxt      = state;
        ph_load  = 1'b0;
        ph_en    = 1'b0;
        ph_val   = '0;
        pc_clr   = 1'b0;
        pc_inc   = 1'b0;
        done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    nxt     = DELAY;
                    ph_load = 1'b1;
                    ph_val  = TD_LD;
                    pc_clr  = 1'b1;
                end
            end
            DELAY: begin
                if (bus.stop) begin
                    nxt = IDLE;
                end else if (ph_zero) begin
                    nxt     = HIGH;
                    ph_load = 1'b1;
                    ph_val  = HI_LD;
                end else begin
                    ph_en = 1'b1;
                end
            end
            HIGH: begin
                if (bus.stop) begin
                    nxt = IDLE;
                end else if (ph_zero) begin
                    nxt     = LOW;
                    ph_load = 1'b1;
                    ph_val  = LO_LD;
                end else begin
                    ph_en = 1'b1;
                end
            end
            LOW: begin
                if (bus.stop) begin
                    nxt = IDLE;
                end else if (ph_zero) begin
                    pc_inc = 1'b1;
                    if (N_PULSE != 0 && pulse_inc == N_TGT) begin
                        nxt      = IDLE;
                        done_nxt = 1'b1;
                    end else begin
                        nxt     = HIGH;
                        ph_load = 1'b1;
                        ph_val  = HI_LD;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Pulse counter, saturating so free-running bursts never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt <= '0;
        end else if (pc_clr) begin
            pulse_cnt <= '0;
        end else if (pc_inc) begin
            pulse_cnt <= pulse_inc;
        end
    end

    // Registered outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.out  <= (nxt == HIGH);
            bus.busy <= is_busy(nxt);
            bus.done <= done_nxt;
        end
    end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 The block SHALL have parameter TD_CYC, default 1: clocks from start acceptance to the first rising edge of out, minus one.
REQ-002 The block SHALL have parameter TW_CYC, default 4: high width of each pulse, in clocks.
REQ-003 The block SHALL have parameter TP_CYC, default 8: pulse period, in clocks; legal range 1 <= TW_CYC < TP_CYC.
REQ-004 The block SHALL have parameter N_PULSE, default 0: number of pulses per burst; 0 means run until stop.
REQ-005 The block SHALL have parameter CNT_W, default 16: width of all internal counters.
REQ-006 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous and active-high.
REQ-008 Port start, input, 1: level-sampled burst request.
REQ-009 Port stop, input, 1: level-sampled abort request.
REQ-010 Port out, output, 1: registered pulse bit, intended to drive a bit2pwl/ipulse-style PWL converter.
REQ-011 Port busy, output, 1: high while a burst is in progress.
REQ-012 Port done, output, 1: one-clock strobe at burst completion.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, DELAY, HIGH and LOW.
REQ-014 In IDLE, start=1 with stop=0 SHALL move the FSM to DELAY, load the delay counter with TD_CYC and clear the pulse counter.
REQ-015 In DELAY, the delay counter SHALL decrement each clock; at zero the FSM SHALL enter HIGH, so out rises exactly TD_CYC+1 clocks after the accepting edge.
REQ-016 HIGH SHALL last TW_CYC clocks with out=1, then the FSM SHALL enter LOW.
REQ-017 LOW SHALL last TP_CYC-TW_CYC clocks with out=0.
REQ-018 At the end of LOW, the pulse counter SHALL increment.
REQ-019 At the end of LOW, if N_PULSE!=0 and the count equals N_PULSE, the FSM SHALL enter IDLE and assert done for one clock; otherwise it SHALL enter HIGH.
REQ-020 out SHALL be a registered output, high only in HIGH, with no combinational path from any input.
REQ-021 busy SHALL be 1 in DELAY, HIGH and LOW, and 0 in IDLE.
REQ-022 start asserted while busy=1 SHALL be ignored; no restart and no counter reload.
REQ-023 stop=1 in any non-IDLE state SHALL force out=0 and the FSM to IDLE on the next edge, with done=0.
REQ-024 When start and stop are both 1 in IDLE, stop SHALL win and the FSM SHALL remain in IDLE.
REQ-025 A start held high continuously after a finite burst SHALL re-arm the block on the clock after done.
REQ-026 The pulse counter SHALL saturate at 2^CNT_W-1 when N_PULSE=0 and SHALL NOT wrap.
REQ-027 Illegal parameters (TW_CYC>=TP_CYC, TW_CYC=0, or any value >= 2^CNT_W) SHALL trigger an elaboration-time $error.

Reset
REQ-028 Asserting rst SHALL immediately set state=IDLE, out=0, busy=0, done=0 and clear all counters, including in the middle of a burst.
REQ-029 After rst deasserts, the first start SHALL be accepted no earlier than the first rising edge of clk.

Structure
REQ-030 The state enum and a cycle-count typedef sized by CNT_W SHALL live in shared package pulse_gen_pkg.
REQ-031 One reusable sub-module, cyc_downcnt (load/enable/zero-flag down counter), SHALL time the DELAY, HIGH and LOW phases.
REQ-032 The pulse counter SHALL stay local to pulse_burst_gen.

Verification
REQ-033 Defaults, N_PULSE=3, 1-clock start: out rises 2 clocks after acceptance; 3 pulses of 4 high / 4 low; done strobes once; busy=1 for exactly 26 clocks.
REQ-034 N_PULSE=0, start, then stop during the 5th HIGH: out=0 and busy=0 on the next edge; done never asserts.
REQ-035 rst pulsed asynchronously mid-HIGH (between clk edges): out, busy and done go to 0 without waiting for a clock edge; the next start behaves as in REQ-033.
REQ-036 start held high for 40 clocks with N_PULSE=2: the second start during a burst is ignored; a new burst begins one clock after each done.
REQ-037 TD_CYC=0, TW_CYC=1, TP_CYC=2: out rises 1 clock after acceptance and toggles every clock.
REQ-038 start=stop=1 in IDLE: no state change; busy stays 0.
